// File: rtl/hsync_pkg.sv
// -----------------------------------------------------------------------------
// hsync_pkg
//   Shared definitions for the REQ/ACK CDC handshake controller.
//   - HSYNC_MIN_STAGES : smallest legal depth of the REQ synchronizer
//   - hsync_state_e    : controller state encoding (2'd3 is unused)
// -----------------------------------------------------------------------------
package hsync_pkg;

    localparam int HSYNC_MIN_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VALID  = 2'd1,
        ST_ACKING = 2'd2
    } hsync_state_e;

endpackage : hsync_pkg

// File: rtl/hsync_req_sync.sv
// -----------------------------------------------------------------------------
// hsync_req_sync
//   NUM_STAGES-deep single-bit synchronizer for an asynchronous level.
//   Ports:
//     clk      in   destination clock
//     rst      in   asynchronous, active-high reset (clears the whole chain)
//     async_in in   asynchronous input level
//     sync_out out  input level after NUM_STAGES flops
// -----------------------------------------------------------------------------
module hsync_req_sync
    import hsync_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    generate
        if (NUM_STAGES < HSYNC_MIN_STAGES) begin : g_bad_depth
            $error("hsync_req_sync: NUM_STAGES must be >= HSYNC_MIN_STAGES");
        end
    endgenerate

    logic [NUM_STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples the value its neighbour held before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[NUM_STAGES-1];

endmodule : hsync_req_sync

// File: rtl/hsync_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// hsync_handshake_ctrl
//   Destination-side controller for a 4-phase REQ/ACK multi-bit CDC transfer.
//   REQ is synchronized, its rising edge captures the quasi-static source bus
//   once, the word is offered on a valid/ready interface and ACK is returned
//   to the source until it withdraws REQ.
//
//   Ports:
//     CLK         in   destination clock (rising edge)
//     RST         in   asynchronous, active-high reset
//     ASYNC_REQ   in   source request, asynchronous to CLK
//     ASYNC_DATA  in   source data, stable from REQ rise until ACK is seen
//     SYNC_READY  in   consumer ready
//     SYNC_DATA   out  captured word (registered)
//     SYNC_VALID  out  captured word valid (registered)
//     ACK         out  acknowledge to source (registered, glitch-free)
//     BUSY        out  high whenever the controller is not IDLE
//   Optional (macro HSYNC_PARITY_EN):
//     ASYNC_PAR   in   even parity of ASYNC_DATA, same stability as the data
//     PAR_ERR     out  parity mismatch of the captured word, valid with
//                      SYNC_VALID (registered)
// -----------------------------------------------------------------------------
module hsync_handshake_ctrl
    import hsync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ASYNC_REQ,
    input  logic [BUS_WIDTH-1:0] ASYNC_DATA,
    input  logic                 SYNC_READY,
    output logic [BUS_WIDTH-1:0] SYNC_DATA,
    output logic                 SYNC_VALID,
    output logic                 ACK,
    output logic                 BUSY
`ifdef HSYNC_PARITY_EN
    ,
    input  logic                 ASYNC_PAR,
    output logic                 PAR_ERR
`endif
);

    generate
        if (NUM_STAGES < HSYNC_MIN_STAGES) begin : g_bad_depth
            $error("hsync_handshake_ctrl: NUM_STAGES must be >= HSYNC_MIN_STAGES");
        end
    endgenerate

    hsync_state_e state;
    logic         req_s;
    logic         req_d;
    logic         rise;

    hsync_req_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (ASYNC_REQ),
        .sync_out (req_s)
    );

    // One extra flop after the synchronizer for edge detection; a level that
    // stays high never produces a second rise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_d <= 1'b0;
        end else begin
            req_d <= req_s;
        end
    end

    assign rise = req_s & ~req_d;

    // ASYNC_DATA is only sampled once req_s has risen, i.e. NUM_STAGES edges
    // after REQ, by which time the source guarantees the bus is settled.
    // NOTE: the capture register is reset along with the control flops because
    // SYNC_DATA must read 0 after reset, not whatever the last word was.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            SYNC_DATA  <= '0;
            SYNC_VALID <= 1'b0;
            ACK        <= 1'b0;
`ifdef HSYNC_PARITY_EN
            PAR_ERR    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        SYNC_DATA  <= ASYNC_DATA;
                        SYNC_VALID <= 1'b1;
`ifdef HSYNC_PARITY_EN
                        PAR_ERR    <= (^ASYNC_DATA) ^ ASYNC_PAR;
`endif
                        state      <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // VALID was set on the previous edge, so the beat is
                    // always visible for a full cycle before READY is honoured.
                    if (SYNC_READY) begin
                        SYNC_VALID <= 1'b0;
                        ACK        <= 1'b1;
`ifdef HSYNC_PARITY_EN
                        PAR_ERR    <= 1'b0;
`endif
                        state      <= ST_ACKING;
                    end
                end
                ST_ACKING: begin
                    // If the source already dropped REQ during VALID, this
                    // exits on the first edge and ACK is a single-cycle pulse.
                    if (!req_s) begin
                        ACK   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    SYNC_DATA  <= '0;
                    SYNC_VALID <= 1'b0;
                    ACK        <= 1'b0;
`ifdef HSYNC_PARITY_EN
                    PAR_ERR    <= 1'b0;
`endif
                end
            endcase
        end
    end

`ifdef HSYNC_PARITY_EN
    // Parity build: PAR_ERR is produced by the controller register above.
`else
    // Plain build: no parity ports or logic.
`endif

    assign BUSY = (state != ST_IDLE);

endmodule : hsync_handshake_ctrl

// File: tb/tb_hsync_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hsync_handshake_ctrl
//   Directed bench for hsync_handshake_ctrl (BUS_WIDTH=8, NUM_STAGES=2, T=10ns).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
//   Define HSYNC_PARITY_EN to also exercise the parity option.
// -----------------------------------------------------------------------------
module tb_hsync_handshake_ctrl;

    logic       CLK;
    logic       RST;
    logic       ASYNC_REQ;
    logic [7:0] ASYNC_DATA;
    logic       SYNC_READY;
    logic [7:0] SYNC_DATA;
    logic       SYNC_VALID;
    logic       ACK;
    logic       BUSY;
`ifdef HSYNC_PARITY_EN
    logic       ASYNC_PAR;
    logic       PAR_ERR;
`endif

    int total = 0;
    int bad   = 0;

    hsync_handshake_ctrl #(
        .BUS_WIDTH  (8),
        .NUM_STAGES (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ASYNC_REQ  (ASYNC_REQ),
        .ASYNC_DATA (ASYNC_DATA),
        .SYNC_READY (SYNC_READY),
        .SYNC_DATA  (SYNC_DATA),
        .SYNC_VALID (SYNC_VALID),
        .ACK        (ACK),
        .BUSY       (BUSY)
`ifdef HSYNC_PARITY_EN
        ,
        .ASYNC_PAR  (ASYNC_PAR),
        .PAR_ERR    (PAR_ERR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 ns.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Outputs in one shot: {valid, ack, busy}.
    task automatic check_ctl(input string tag, input logic v, input logic a, input logic b);
        check({tag, ".ctl"}, {29'd0, SYNC_VALID, ACK, BUSY}, {29'd0, v, a, b});
    endtask

    int         beats;
    logic [7:0] beat_data [2];

    initial begin
        RST        = 1'b0;
        ASYNC_REQ  = 1'b0;
        ASYNC_DATA = 8'h00;
        SYNC_READY = 1'b0;
`ifdef HSYNC_PARITY_EN
        ASYNC_PAR  = 1'b0;
`endif

        // 1. Reset asserted mid-cycle clears outputs immediately.
        #7;
        RST = 1'b1;
        #1;
        check_ctl("rst_async", 1'b0, 1'b0, 1'b0);
        check("rst_async.data", {24'd0, SYNC_DATA}, 32'h0);
        tick(2);
        RST = 1'b0;
        tick(2);
        check_ctl("rst_release", 1'b0, 1'b0, 1'b0);
        check("rst_release.data", {24'd0, SYNC_DATA}, 32'h0);

        // 2. Basic transfer; REQ first sampled at edge k, VALID after k+2.
        ASYNC_DATA = 8'hA5;
        SYNC_READY = 1'b1;
        ASYNC_REQ  = 1'b1;
        tick(1);                                   // edge k
        check_ctl("basic.k", 1'b0, 1'b0, 1'b0);
        tick(1);                                   // edge k+1
        check_ctl("basic.k1", 1'b0, 1'b0, 1'b0);
        tick(1);                                   // edge k+2
        check_ctl("basic.k2", 1'b1, 1'b0, 1'b1);
        check("basic.data", {24'd0, SYNC_DATA}, 32'hA5);
        tick(1);
        check_ctl("basic.ack", 1'b0, 1'b1, 1'b1);
        ASYNC_REQ = 1'b0;
        tick(2);
        check_ctl("basic.ack_hold", 1'b0, 1'b1, 1'b1);
        tick(1);
        check_ctl("basic.done", 1'b0, 1'b0, 1'b0);

        // 3. Backpressure: word and VALID held while READY is low.
        SYNC_READY = 1'b0;
        ASYNC_DATA = 8'h3C;
        ASYNC_REQ  = 1'b1;
        tick(3);
        check_ctl("bp.valid", 1'b1, 1'b0, 1'b1);
        ASYNC_DATA = 8'hFF;                        // captured word must not follow the bus
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_ctl("bp.hold", 1'b1, 1'b0, 1'b1);
            check("bp.hold.data", {24'd0, SYNC_DATA}, 32'h3C);
        end
        SYNC_READY = 1'b1;
        tick(1);
        check_ctl("bp.release", 1'b0, 1'b1, 1'b1);
        ASYNC_REQ = 1'b0;
        tick(3);
        check_ctl("bp.done", 1'b0, 1'b0, 1'b0);

        // 4. Back-to-back with REQ held high: exactly one beat per REQ.
        beats = 0;
        SYNC_READY = 1'b1;
        for (int w = 0; w < 2; w++) begin
            ASYNC_DATA = (w == 0) ? 8'h01 : 8'hFE;
            ASYNC_REQ  = 1'b1;
            for (int c = 0; c < 20; c++) begin
                tick(1);
                if (SYNC_VALID) begin
                    if (beats < 2) beat_data[beats] = SYNC_DATA;
                    beats++;
                end
            end
            ASYNC_REQ = 1'b0;
            for (int c = 0; c < 5; c++) begin
                tick(1);
                if (SYNC_VALID) beats++;
            end
        end
        check("b2b.beats", beats, 32'd2);
        check("b2b.first", {24'd0, beat_data[0]}, 32'h01);
        check("b2b.second", {24'd0, beat_data[1]}, 32'hFE);
        check_ctl("b2b.done", 1'b0, 1'b0, 1'b0);

        // 5. Reset while VALID, then a clean transfer.
        SYNC_READY = 1'b0;
        ASYNC_DATA = 8'h77;
        ASYNC_REQ  = 1'b1;
        tick(3);
        check_ctl("rstv.valid", 1'b1, 1'b0, 1'b1);
        #3;
        RST = 1'b1;
        #1;
        check_ctl("rstv.async", 1'b0, 1'b0, 1'b0);
        check("rstv.data", {24'd0, SYNC_DATA}, 32'h0);
        ASYNC_REQ = 1'b0;
        tick(2);
        RST = 1'b0;
        tick(3);
        SYNC_READY = 1'b1;
        ASYNC_DATA = 8'h5A;
        ASYNC_REQ  = 1'b1;
        tick(3);
        check_ctl("rstv.re_valid", 1'b1, 1'b0, 1'b1);
        check("rstv.re_data", {24'd0, SYNC_DATA}, 32'h5A);
        tick(1);
        check_ctl("rstv.re_ack", 1'b0, 1'b1, 1'b1);
        ASYNC_REQ = 1'b0;
        tick(3);
        check_ctl("rstv.re_done", 1'b0, 1'b0, 1'b0);

        // Reset while ACKING drops ACK asynchronously.
        ASYNC_DATA = 8'h11;
        ASYNC_REQ  = 1'b1;
        tick(4);
        check_ctl("rsta.acking", 1'b0, 1'b1, 1'b1);
        #3;
        RST = 1'b1;
        #1;
        check_ctl("rsta.async", 1'b0, 1'b0, 1'b0);
        ASYNC_REQ = 1'b0;
        tick(2);
        RST = 1'b0;
        tick(3);

        // REQ dropped while VALID: word still delivered, ACK is a 1-cycle pulse.
        SYNC_READY = 1'b0;
        ASYNC_DATA = 8'h99;
        ASYNC_REQ  = 1'b1;
        tick(3);
        check_ctl("drop.valid", 1'b1, 1'b0, 1'b1);
        ASYNC_REQ = 1'b0;
        tick(3);
        check_ctl("drop.still_valid", 1'b1, 1'b0, 1'b1);
        check("drop.data", {24'd0, SYNC_DATA}, 32'h99);
        SYNC_READY = 1'b1;
        tick(1);
        check_ctl("drop.ack", 1'b0, 1'b1, 1'b1);
        tick(1);
        check_ctl("drop.ack_pulse", 1'b0, 1'b0, 1'b0);

`ifdef HSYNC_PARITY_EN
        // 6. Parity: 8'h07 has odd bit count, so even-parity bit is 1.
        SYNC_READY = 1'b0;
        ASYNC_DATA = 8'h07;
        ASYNC_PAR  = 1'b1;
        ASYNC_REQ  = 1'b1;
        tick(3);
        check_ctl("par_ok.valid", 1'b1, 1'b0, 1'b1);
        check("par_ok.err", {31'd0, PAR_ERR}, 32'd0);
        SYNC_READY = 1'b1;
        tick(1);
        ASYNC_REQ = 1'b0;
        tick(3);
        SYNC_READY = 1'b0;
        ASYNC_PAR  = 1'b0;
        ASYNC_REQ  = 1'b1;
        tick(3);
        check_ctl("par_bad.valid", 1'b1, 1'b0, 1'b1);
        check("par_bad.err", {31'd0, PAR_ERR}, 32'd1);
        SYNC_READY = 1'b1;
        tick(1);
        check_ctl("par_bad.ack", 1'b0, 1'b1, 1'b1);
        check("par_bad.cleared", {31'd0, PAR_ERR}, 32'd0);
        ASYNC_REQ = 1'b0;
        tick(3);
        check_ctl("par_bad.done", 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hsync_handshake_ctrl
